// File: rtl/issue_scoreboard_if.sv
// Decode/execute/writeback bundle for the dual-issue scoreboard.
// The master drives the decode slots and writebacks; the slave returns issue decisions and state.
interface issue_scoreboard_if #(
   parameter int unsigned AW   = 3,
   parameter int unsigned NREG = 8
);
   logic            flush;
   logic            s0_valid;
   logic [AW-1:0]   s0_src1;
   logic [AW-1:0]   s0_src2;
   logic [AW-1:0]   s0_dst;
   logic            s0_wr;
   logic            s1_valid;
   logic [AW-1:0]   s1_src1;
   logic [AW-1:0]   s1_src2;
   logic [AW-1:0]   s1_dst;
   logic            s1_wr;
   logic            ex_ready;
   logic            wb0_valid;
   logic [AW-1:0]   wb0_addr;
   logic            wb1_valid;
   logic [AW-1:0]   wb1_addr;
   logic            issue0;
   logic            issue1;
   logic [1:0]      consumed;
   logic            stall_if;
   logic [NREG-1:0] busy_vec;
   logic [15:0]     stall_cnt;
   logic            wb_err;

   modport master (
      output flush, s0_valid, s0_src1, s0_src2, s0_dst, s0_wr,
             s1_valid, s1_src1, s1_src2, s1_dst, s1_wr,
             ex_ready, wb0_valid, wb0_addr, wb1_valid, wb1_addr,
      input  issue0, issue1, consumed, stall_if, busy_vec, stall_cnt, wb_err
   );

   modport slave (
      input  flush, s0_valid, s0_src1, s0_src2, s0_dst, s0_wr,
             s1_valid, s1_src1, s1_src2, s1_dst, s1_wr,
             ex_ready, wb0_valid, wb0_addr, wb1_valid, wb1_addr,
      output issue0, issue1, consumed, stall_if, busy_vec, stall_cnt, wb_err
   );
endinterface

// File: rtl/issue_scoreboard.sv
// Dual-issue scoreboard: in-order issue of up to two decode slots with RAW/WAW checks
// against registered pending-write bits, writeback clears and a timed flush window.
module issue_scoreboard #(
   parameter int unsigned NREG      = 8,
   parameter int unsigned AW        = 3,
   parameter int unsigned FLUSH_CYC = 2
) (
   input logic               clk,
   input logic               reset,
   issue_scoreboard_if.slave bus
);
   localparam int unsigned CW  = 4;
   localparam int unsigned SCW = 16;

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_flush_cnt;
   logic [NREG-1:0] r_busy;
   logic [SCW-1:0]  r_stall_cnt;
   logic            r_wb_err;

   logic            w_run;
   logic            w_s0_ok;
   logic            w_s1_ok;
   logic            w_s1_dep;
   logic            w_issue0;
   logic            w_issue1;
   logic            w_stall;
   logic            w_wb_err;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_clr;
   logic [NREG-1:0] w_busy_nxt;

   function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
      onehot = NREG'(1) << a;
   endfunction

   // Issue decisions look only at the registered busy bits (no writeback bypass).
   assign w_run    = (r_state == ST_RUN) & ~bus.flush & ~reset;
   assign w_s0_ok  = bus.s0_valid & bus.ex_ready & ~r_busy[bus.s0_src1] & ~r_busy[bus.s0_src2]
                   & ~(bus.s0_wr & r_busy[bus.s0_dst]);
   assign w_s1_ok  = bus.s1_valid & ~r_busy[bus.s1_src1] & ~r_busy[bus.s1_src2]
                   & ~(bus.s1_wr & r_busy[bus.s1_dst]);
   assign w_s1_dep = bus.s0_wr & ((bus.s1_src1 == bus.s0_dst) | (bus.s1_src2 == bus.s0_dst)
                   | (bus.s1_wr & (bus.s1_dst == bus.s0_dst)));
   assign w_issue0 = w_run & w_s0_ok;
   assign w_issue1 = w_issue0 & w_s1_ok & ~w_s1_dep;
   assign w_stall  = w_run & ((bus.s0_valid & ~w_issue0) | (bus.s1_valid & ~w_issue1));

   // New pending writes take priority over a same-cycle clear of the same register.
   assign w_set      = ((w_issue0 & bus.s0_wr) ? onehot(bus.s0_dst) : '0)
                     | ((w_issue1 & bus.s1_wr) ? onehot(bus.s1_dst) : '0);
   assign w_clr      = (bus.wb0_valid ? onehot(bus.wb0_addr) : '0)
                     | (bus.wb1_valid ? onehot(bus.wb1_addr) : '0);
   assign w_busy_nxt = (r_busy & ~w_clr) | w_set;
   assign w_wb_err   = (bus.wb0_valid & ~r_busy[bus.wb0_addr])
                     | (bus.wb1_valid & ~r_busy[bus.wb1_addr]);

   assign bus.issue0    = w_issue0;
   assign bus.issue1    = w_issue1;
   assign bus.consumed  = 2'(w_issue0) + 2'(w_issue1);
   assign bus.stall_if  = w_stall;
   assign bus.busy_vec  = r_busy;
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.wb_err    = r_wb_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= '0;
         r_busy      <= '0;
         r_stall_cnt <= '0;
         r_wb_err    <= 1'b0;
      end else begin
         r_busy   <= w_busy_nxt;
         r_wb_err <= r_wb_err | w_wb_err;
         if (w_stall && (r_stall_cnt != {SCW{1'b1}}))
            r_stall_cnt <= r_stall_cnt + SCW'(1);
         // Flush window: counter reloads on every flush and releases to RUN after the last cycle.
         case (r_state)
            ST_RUN: begin
               if (bus.flush) begin
                  r_state     <= ST_FLUSH;
                  r_flush_cnt <= CW'(FLUSH_CYC);
               end
            end
            ST_FLUSH: begin
               if (bus.flush) begin
                  r_flush_cnt <= CW'(FLUSH_CYC);
               end else if (r_flush_cnt <= CW'(1)) begin
                  r_state     <= ST_RUN;
                  r_flush_cnt <= '0;
               end else begin
                  r_flush_cnt <= r_flush_cnt - CW'(1);
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end
endmodule
